goldschmidt_ctrl: RTL

//  Sequencer FSM that drives the Goldschmidt divider datapath control inputs
//  (load_regN, load_regD, sel_ND_mux, sel_K_mux) for one division per start.

---
 rtl/goldschmidt_pkg.sv | 48 ++++
 rtl/goldschmidt_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/goldschmidt_pkg.sv
// goldschmidt_pkg
//   Shared types and constants for the Goldschmidt divider sequencer.
//   - state_t   : sequencer states
//   - SEL_*     : datapath N/D operand-select codes
//   - KSEL_*    : multiplier-select codes (IA seed or K = 2-D)
//   - ctl_t     : bundle of datapath control outputs
//   - ctl_decode: Moore decode of the control bundle from a state
package goldschmidt_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INIT_D  = 3'd1,
      INIT_N  = 3'd2,
      ITER_D  = 3'd3,
      ITER_N  = 3'd4,
      CAPTURE = 3'd5,
      DONE    = 3'd6
   } state_t;

   localparam logic [1:0] SEL_IA_D = 2'b00;
   localparam logic [1:0] SEL_IA_N = 2'b01;
   localparam logic [1:0] SEL_K_D  = 2'b10;
   localparam logic [1:0] SEL_K_N  = 2'b11;

   localparam logic KSEL_IA = 1'b1;
   localparam logic KSEL_K  = 1'b0;

   typedef struct packed {
      logic       load_n;
      logic       load_d;
      logic [1:0] sel_nd;
      logic       sel_k;
   } ctl_t;

   function automatic ctl_t ctl_decode(input state_t s);
      ctl_t c;
      c = '{load_n: 1'b0, load_d: 1'b0, sel_nd: SEL_IA_D, sel_k: KSEL_IA};
      case (s)
         INIT_D: c = '{load_n: 1'b0, load_d: 1'b1, sel_nd: SEL_IA_D, sel_k: KSEL_IA};
         INIT_N: c = '{load_n: 1'b1, load_d: 1'b0, sel_nd: SEL_IA_N, sel_k: KSEL_IA};
         ITER_D: c = '{load_n: 1'b0, load_d: 1'b1, sel_nd: SEL_K_D,  sel_k: KSEL_K};
         ITER_N: c = '{load_n: 1'b1, load_d: 1'b0, sel_nd: SEL_K_N,  sel_k: KSEL_K};
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/goldschmidt_ctrl.sv
// goldschmidt_ctrl
//   Sequencer for the Goldschmidt divider datapath. One division per accepted
//   start: seed pair (IA*D, IA*N), ITERS refinement pairs (K*D, K*N), then the
//   datapath result is captured into the quotient register and done pulses.
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   start      in   division request, sampled only while ready=1
//   ready      out  1 in IDLE
//   busy       out  1 from INIT_D through CAPTURE
//   done       out  one-cycle pulse, quotient valid
//   load_regN  out  datapath N-register load enable
//   load_regD  out  datapath D-register load enable
//   sel_ND_mux out  datapath operand select
//   sel_K_mux  out  1 = IA multiplier, 0 = K multiplier
//   result_in  in   datapath result bus
//   quotient   out  registered quotient, held until the next capture
module goldschmidt_ctrl
   import goldschmidt_pkg::*;
#(
   parameter int unsigned W     = 16,
   parameter int unsigned ITERS = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic         load_regN,
   output logic         load_regD,
   output logic [1:0]   sel_ND_mux,
   output logic         sel_K_mux,
   input  logic [W-1:0] result_in,
   output logic [W-1:0] quotient
);

   localparam int unsigned CW = $clog2(ITERS + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_next;
   ctl_t          r_ctl;
   logic          r_ready;
   logic          r_busy;
   logic          r_done;
   logic [W-1:0]  r_quot;

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next     = INIT_D;
               w_cnt_next = '0;
            end
         end
         INIT_D:  w_next = INIT_N;
         INIT_N:  w_next = ITER_D;
         ITER_D:  w_next = ITER_N;
         ITER_N: begin
            if (r_cnt == LAST_ITER) begin
               w_next = CAPTURE;
            end else begin
               w_next     = ITER_D;
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         CAPTURE: w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs are registered from the decode of the next state, so they are
   // exactly the Moore values of the state held during the following cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ctl   <= ctl_decode(IDLE);
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_quot  <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         r_ctl   <= ctl_decode(w_next);
         r_ready <= (w_next == IDLE);
         r_busy  <= (w_next == INIT_D) || (w_next == INIT_N) || (w_next == ITER_D) ||
                    (w_next == ITER_N) || (w_next == CAPTURE);
         r_done  <= (w_next == DONE);
         if (r_state == CAPTURE) begin
            r_quot <= result_in;
         end
      end
   end

   assign ready      = r_ready;
   assign busy       = r_busy;
   assign done       = r_done;
   assign load_regN  = r_ctl.load_n;
   assign load_regD  = r_ctl.load_d;
   assign sel_ND_mux = r_ctl.sel_nd;
   assign sel_K_mux  = r_ctl.sel_k;
   assign quotient   = r_quot;

endmodule
